// File: rtl/bottle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bottle_pkg
//  Purpose  : Shared state encoding and default setpoint constants for the
//             bottle-filling mode/counting controller.
//  Contents : state_e      - controller state, value = {EN_work, EN_set}
//             c_*          - default widths, setpoints and debounce window
//  Revision : 1.0  initial release
// ============================================================================
package bottle_pkg;

    // The encoding is visible on the outputs, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_WORK  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int c_CNT_W          = 8;
    localparam int c_DEF_PER_BOTTLE = 10;
    localparam int c_DEF_BOTTLES    = 5;
    localparam int c_MAX_SET        = 99;
    localparam int c_DB_CYCLES      = 16;

endpackage : bottle_pkg
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
//  Module   : key_edge
//  Purpose  : Optional debounce filter followed by a registered rising-edge
//             detector. Produces one single-cycle pulse per rising edge of
//             the (filtered) level; a held input gives exactly one pulse.
//  Params   : DEBOUNCE  - 1: level must be stable DB_CYCLES cycles before the
//                         filtered level follows it; 0: raw level is used
//             DB_CYCLES - debounce stability window in CLK cycles (>= 2)
//  Ports    : CLK      in  clock, posedge
//             RST      in  synchronous active-high reset
//             i_level  in  raw input level
//             o_pulse  out registered one-cycle rising-edge pulse
//  Revision : 1.0  initial release
// ============================================================================
module key_edge #(
    parameter bit DEBOUNCE  = 1'b0,
    parameter int DB_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_level,
    output logic o_pulse
);

    localparam int c_CW = $clog2(DB_CYCLES + 1);

    logic            r_filt;
    logic [c_CW-1:0] r_cnt;
    logic            r_prev;
    logic            r_pulse;
    logic            w_level;

    // Filter: counts consecutive cycles in which the raw level disagrees
    // with the filtered level; any agreement restarts the window. When the
    // filter is not selected the mux drops it and synthesis prunes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (i_level == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CW'(DB_CYCLES - 1)) begin
            r_filt <= i_level;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign w_level = DEBOUNCE ? r_filt : i_level;

    // The pulse itself is registered so downstream logic sees a clean,
    // glitch-free single-cycle strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_pulse <= w_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule : key_edge
`default_nettype wire

// File: rtl/bottle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : bottle_ctrl_fsm
//  Purpose  : Mode/counting controller for the bottle-filling machine. Turns
//             front-panel keys and the pill sensor into the state code
//             {EN_work,EN_set}, setpoint select SET and allFull, and keeps
//             setpoints and live pill/bottle counts.
//  Config   : KEY_DEBOUNCE_EN - when defined, key_* inputs are debounced
//             over DB_CYCLES cycles before edge detection (pill_in never is)
//  Ports    : CLK, RST                 clock / sync active-high reset
//             key_start/set/sel/inc    front-panel keys (levels)
//             pill_in                  pill sensor (one rising edge = 1 pill)
//             EN_work, EN_set          state code bits 1 / 0
//             SET                      0 = per_bottle, 1 = bottle_target
//             allFull                  bottle target reached
//             pill_cnt, bottle_cnt     live counts
//             per_bottle, bottle_target setpoints
//  Revision : 1.0  initial release
// ============================================================================
module bottle_ctrl_fsm
    import bottle_pkg::*;
#(
    parameter int CNT_W          = c_CNT_W,
    parameter int DEF_PER_BOTTLE = c_DEF_PER_BOTTLE,
    parameter int DEF_BOTTLES    = c_DEF_BOTTLES,
    parameter int MAX_SET        = c_MAX_SET,
    parameter int DB_CYCLES      = c_DB_CYCLES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             key_start,
    input  logic             key_set,
    input  logic             key_sel,
    input  logic             key_inc,
    input  logic             pill_in,
    output logic             EN_work,
    output logic             EN_set,
    output logic             SET,
    output logic             allFull,
    output logic [CNT_W-1:0] pill_cnt,
    output logic [CNT_W-1:0] bottle_cnt,
    output logic [CNT_W-1:0] per_bottle,
    output logic [CNT_W-1:0] bottle_target
);

`ifdef KEY_DEBOUNCE_EN
    localparam bit c_KEY_DB = 1'b1;
`else
    localparam bit c_KEY_DB = 1'b0;
`endif

    logic w_start_p, w_set_p, w_sel_p, w_inc_p, w_pill_p;

    key_edge #(.DEBOUNCE(c_KEY_DB), .DB_CYCLES(DB_CYCLES)) u_key_start (
        .CLK(CLK), .RST(RST), .i_level(key_start), .o_pulse(w_start_p));
    key_edge #(.DEBOUNCE(c_KEY_DB), .DB_CYCLES(DB_CYCLES)) u_key_set (
        .CLK(CLK), .RST(RST), .i_level(key_set),   .o_pulse(w_set_p));
    key_edge #(.DEBOUNCE(c_KEY_DB), .DB_CYCLES(DB_CYCLES)) u_key_sel (
        .CLK(CLK), .RST(RST), .i_level(key_sel),   .o_pulse(w_sel_p));
    key_edge #(.DEBOUNCE(c_KEY_DB), .DB_CYCLES(DB_CYCLES)) u_key_inc (
        .CLK(CLK), .RST(RST), .i_level(key_inc),   .o_pulse(w_inc_p));
    // The pill sensor is a clean electrical signal; never filtered.
    key_edge #(.DEBOUNCE(1'b0),     .DB_CYCLES(DB_CYCLES)) u_pill (
        .CLK(CLK), .RST(RST), .i_level(pill_in),   .o_pulse(w_pill_p));

    state_e           r_state;
    logic             r_set;
    logic             r_all_full;
    logic [CNT_W-1:0] r_pill_cnt;
    logic [CNT_W-1:0] r_bottle_cnt;
    logic [CNT_W-1:0] r_per_bottle;
    logic [CNT_W-1:0] r_bottle_target;

    logic             w_last_pill;
    logic [CNT_W-1:0] w_bottle_inc;
    logic             w_target_hit;
    logic [CNT_W-1:0] w_per_next;
    logic [CNT_W-1:0] w_target_next;
    logic             w_can_start;

    // Setpoints are never 0, so per_bottle-1 cannot underflow.
    assign w_last_pill   = (r_pill_cnt == r_per_bottle - CNT_W'(1));
    assign w_bottle_inc  = r_bottle_cnt + CNT_W'(1);
    assign w_target_hit  = (w_bottle_inc == r_bottle_target);
    // Wrap MAX_SET -> 1 (the >= also recovers from any out-of-range value).
    assign w_per_next    = (r_per_bottle >= CNT_W'(MAX_SET)) ? CNT_W'(1)
                                                             : r_per_bottle + CNT_W'(1);
    assign w_target_next = (r_bottle_target >= CNT_W'(MAX_SET)) ? CNT_W'(1)
                                                                : r_bottle_target + CNT_W'(1);
    assign w_can_start   = (r_per_bottle != '0) && (r_bottle_target != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= ST_IDLE;
            r_set           <= 1'b0;
            r_all_full      <= 1'b0;
            r_pill_cnt      <= '0;
            r_bottle_cnt    <= '0;
            r_per_bottle    <= CNT_W'(DEF_PER_BOTTLE);
            r_bottle_target <= CNT_W'(DEF_BOTTLES);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // set_p has priority over start_p.
                    if (w_set_p) begin
                        r_state      <= ST_SETUP;
                        r_pill_cnt   <= '0;
                        r_bottle_cnt <= '0;
                    end else if (w_start_p && w_can_start) begin
                        r_state <= ST_WORK;
                    end
                end

                ST_SETUP: begin
                    // inc uses the SET value from before a simultaneous sel.
                    if (w_inc_p) begin
                        if (!r_set) r_per_bottle    <= w_per_next;
                        else        r_bottle_target <= w_target_next;
                    end
                    if (w_sel_p) r_set   <= ~r_set;
                    if (w_set_p) r_state <= ST_IDLE;
                end

                ST_WORK: begin
                    // A pill arriving with start is counted first; reaching
                    // the target overrides the pause.
                    if (w_pill_p && w_last_pill) begin
                        r_pill_cnt   <= '0;
                        r_bottle_cnt <= w_bottle_inc;
                        if (w_target_hit) begin
                            r_state    <= ST_DONE;
                            r_all_full <= 1'b1;
                        end else if (w_start_p) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        if (w_pill_p)  r_pill_cnt <= r_pill_cnt + CNT_W'(1);
                        if (w_start_p) r_state    <= ST_IDLE;
                    end
                end

                ST_DONE: begin
                    if (w_start_p) begin
                        r_state      <= ST_IDLE;
                        r_all_full   <= 1'b0;
                        r_pill_cnt   <= '0;
                        r_bottle_cnt <= '0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign EN_work       = r_state[1];
    assign EN_set        = r_state[0];
    assign SET           = r_set;
    assign allFull       = r_all_full;
    assign pill_cnt      = r_pill_cnt;
    assign bottle_cnt    = r_bottle_cnt;
    assign per_bottle    = r_per_bottle;
    assign bottle_target = r_bottle_target;

endmodule : bottle_ctrl_fsm
`default_nettype wire
